// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port bundle: requesters drive req/addr/data/sw_init,
// the arbiter drives grants, one-hot enables, the data bus and busy.
interface regfile_wr_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) ();
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic                      sw_init;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REGS-1:0]       wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic                      busy;

  modport master (
    output req, req_addr, req_data, sw_init,
    input  gnt, wr_en, wr_data, busy
  );

  modport slave (
    input  req, req_addr, req_data, sw_init,
    output gnt, wr_en, wr_data, busy
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register-file write port, with a zeroing
// sweep of registers 1..NUM_REGS-1 after clr or on sw_init.
module regfile_wr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5
) (
  input  logic                clk,
  input  logic                clr,
  regfile_wr_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(NUM_REGS + 1);

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [PTR_W:0]   REQ_N    = (PTR_W + 1)'(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_REGS - 1);
  localparam logic [31:0]      REGS_N   = 32'(NUM_REGS);

  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                last_q, last_d;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   elig_rot;
  logic [2*NUM_REQ-1:0] elig_dbl;
  logic [PTR_W-1:0]     off;
  logic [PTR_W-1:0]     win;
  logic [PTR_W:0]       win_sum;
  logic [PTR_W:0]       nxt_sum;
  logic                 found;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic                 addr_ok;

  // Rotate eligibility so bit 0 is the pointer slot; lowest set bit wins.
  always_comb begin
    elig     = bus.req & ~gnt_q;
    elig_dbl = {elig, elig} >> ptr_q;
    elig_rot = elig_dbl[NUM_REQ-1:0];
    found    = |elig_rot;
    off      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig_rot[k]) off = PTR_W'(k);
    end
    win_sum = {1'b0, ptr_q} + {1'b0, off};
    if (win_sum >= REQ_N) win_sum = win_sum - REQ_N;
    win     = win_sum[PTR_W-1:0];
    nxt_sum = win_sum + (PTR_W + 1)'(1);
    if (nxt_sum >= REQ_N) nxt_sum = '0;
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
    addr_ok = (sel_addr != '0) && (32'(sel_addr) < REGS_N);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    gnt_d     = '0;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    last_d    = 1'b0;
    unique case (1'b1)
      (state_q == INIT): begin
        wr_en_d   = NUM_REGS'(1) << cnt_q;
        wr_data_d = '0;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          last_d  = 1'b1;
        end
      end
      (state_q == RUN && bus.sw_init): begin
        state_d = INIT;
        cnt_d   = CNT_W'(1);
      end
      (state_q == RUN && !bus.sw_init && found): begin
        gnt_d     = NUM_REQ'(1) << win;
        wr_data_d = sel_data;
        ptr_d     = nxt_sum[PTR_W-1:0];
        if (addr_ok) wr_en_d = NUM_REGS'(1) << sel_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= INIT;
      cnt_q     <= CNT_W'(1);
      ptr_q     <= '0;
      gnt_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      last_q    <= last_d;
    end
  end

  // last_q keeps busy up while the final sweep enable is on the bus.
  assign bus.gnt     = gnt_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q == INIT) | last_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a cycle-level
// reference model of the sweep and round-robin rules.
module tb_regfile_wr_arbiter;
  localparam int NQ = 4;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(
    .NUM_REQ(NQ), .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)
  ) ifc ();

  regfile_wr_arbiter #(
    .NUM_REQ(NQ), .NUM_REGS(NR), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(ifc)
  );

  int n_vec = 0;
  int n_bad = 0;

  logic [AW-1:0] r_addr [NQ];
  logic [DW-1:0] r_data [NQ];
  logic [NQ-1:0] r_req;
  logic          r_init;

  int          m_next;
  int          m_ptr;
  int          m_gnt;
  int          m_en;
  logic [DW-1:0] m_data;
  bit          m_busy;

  task automatic expect_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply();
    ifc.req     = r_req;
    ifc.sw_init = r_init;
    for (int i = 0; i < NQ; i++) begin
      ifc.req_addr[i*AW +: AW] = r_addr[i];
      ifc.req_data[i*DW +: DW] = r_data[i];
    end
  endtask

  task automatic model_reset();
    m_next = 1;
    m_ptr  = 0;
    m_gnt  = -1;
    m_en   = -1;
    m_data = '0;
    m_busy = 1'b1;
  endtask

  task automatic model_step();
    int w;
    w = -1;
    if (m_next != 0) begin
      m_en   = m_next;
      m_data = '0;
      m_gnt  = -1;
      m_busy = 1'b1;
      m_next = (m_next == NR - 1) ? 0 : m_next + 1;
    end else if (r_init) begin
      m_next = 1;
      m_gnt  = -1;
      m_en   = -1;
      m_busy = 1'b1;
    end else begin
      m_busy = 1'b0;
      for (int k = 0; k < NQ; k++) begin
        int i;
        i = (m_ptr + k) % NQ;
        if (w < 0 && r_req[i] && i != m_gnt) w = i;
      end
      if (w >= 0) begin
        m_gnt  = w;
        m_data = r_data[w];
        m_ptr  = (w + 1) % NQ;
        if (int'(r_addr[w]) > 0 && int'(r_addr[w]) < NR)
          m_en = int'(r_addr[w]);
        else
          m_en = -1;
      end else begin
        m_gnt = -1;
        m_en  = -1;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] one;
    logic [63:0] eg;
    logic [63:0] ee;
    one = 64'd1;
    eg  = (m_gnt < 0) ? 64'd0 : (one << m_gnt);
    ee  = (m_en < 0) ? 64'd0 : (one << m_en);
    expect_eq("gnt", 64'(ifc.gnt), eg);
    expect_eq("wr_en", 64'(ifc.wr_en), ee);
    expect_eq("wr_data", 64'(ifc.wr_data), 64'(m_data));
    expect_eq("busy", 64'(ifc.busy), 64'(m_busy));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (!clr) model_step();
    #1;
    check_all();
  endtask

  // Async clr mid-cycle: outputs must clear before the next edge.
  task automatic hit_clr();
    @(negedge clk);
    #1;
    clr = 1'b1;
    model_reset();
    #1;
    check_all();
    cyc();
    cyc();
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic drive_rand();
    for (int i = 0; i < NQ; i++) begin
      if (r_req[i] && m_gnt == i) begin
        if ($urandom_range(0, 1) == 1) begin
          r_addr[i] = AW'($urandom);
          r_data[i] = $urandom;
        end else begin
          r_req[i] = 1'b0;
        end
      end else if (!r_req[i] && $urandom_range(0, 9) < 4) begin
        r_req[i]  = 1'b1;
        r_addr[i] = AW'($urandom);
        r_data[i] = $urandom;
      end
    end
    r_init = ($urandom_range(0, 59) == 0);
    apply();
  endtask

  initial begin
    r_req  = '0;
    r_init = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      r_addr[i] = '0;
      r_data[i] = '0;
    end
    apply();
    model_reset();
    #1;
    clr = 1'b1;
    #1;
    check_all();
    repeat (3) cyc();
    clr = 1'b0;
    repeat (33) cyc();

    r_req     = 4'b0100;
    r_addr[2] = 5'd5;
    r_data[2] = 32'hDEADBEEF;
    apply();
    repeat (6) cyc();
    r_req = '0;
    apply();
    cyc();

    for (int i = 0; i < NQ; i++) begin
      r_addr[i] = AW'(i + 1);
      r_data[i] = 32'hA0 + DW'(i);
    end
    r_req = '1;
    apply();
    repeat (5) cyc();
    r_req = '0;
    apply();
    cyc();

    r_req     = 4'b0010;
    r_addr[1] = '0;
    r_data[1] = 32'h1234;
    apply();
    cyc();
    r_req = '0;
    apply();
    repeat (2) cyc();

    hit_clr();
    repeat (10) cyc();
    hit_clr();
    repeat (33) cyc();

    r_req = '1;
    apply();
    cyc();
    hit_clr();
    r_req = '0;
    apply();
    repeat (33) cyc();

    r_req     = 4'b1000;
    r_addr[3] = 5'd7;
    r_data[3] = 32'hCAFE0007;
    r_init    = 1'b1;
    apply();
    cyc();
    r_init = 1'b0;
    apply();
    repeat (33) cyc();
    r_req = '0;
    apply();
    repeat (2) cyc();

    repeat (800) begin
      drive_rand();
      cyc();
      if ($urandom_range(0, 299) == 0) hit_clr();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
